// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/result and ALU drive bundle for the MUL/DIV sequencer
interface alu_muldiv_seq_if;
  logic       start;
  logic       op;
  logic [7:0] acc_i;
  logic [7:0] b_i;
  logic       busy;
  logic       done;
  logic [7:0] acc_o;
  logic [7:0] b_o;
  logic       ov_o;
  logic       cy_o;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [2:0] alu_method_o;
  logic       alu_cy_o;
  logic [7:0] alu_o_i;
  logic       alu_cy_i;

  modport master (
    output start, op, acc_i, b_i, alu_o_i, alu_cy_i,
    input  busy, done, acc_o, b_o, ov_o, cy_o,
    input  alu_a_o, alu_b_o, alu_method_o, alu_cy_o
  );

  modport slave (
    input  start, op, acc_i, b_i, alu_o_i, alu_cy_i,
    output busy, done, acc_o, b_o, ov_o, cy_o,
    output alu_a_o, alu_b_o, alu_method_o, alu_cy_o
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 8-iteration MUL AB / DIV AB sequencer driving the shared ALU
// Define ALU_MULDIV_DIV_EN to build the restoring divider; otherwise DIV returns operands with OV set.
module alu_muldiv_seq (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] m;
  logic       busy_q;
  logic       done_q;
  logic [7:0] acc_q;
  logic [7:0] b_q;
  logic       ov_q;
  logic       cy_q;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_method;
  logic       bypass;

  logic [7:0] mul_b;
  logic [7:0] mul_hi_nx;
  logic [7:0] mul_lo_nx;

  // MUL: P_hi in r_hi, P_lo in r_lo, multiplicand in m.
  always_comb begin
    mul_b     = r_lo[0] ? m : 8'h00;
    mul_hi_nx = {bus.alu_cy_i, bus.alu_o_i[7:1]};
    mul_lo_nx = {bus.alu_o_i[0], r_lo[7:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  logic       op_q;
  logic       div_r8;
  logic [7:0] div_rs;
  logic       div_accept;
  logic [7:0] div_r_nx;
  logic [7:0] div_q_nx;

  // DIV: R in r_hi, Q in r_lo, divisor in m. r8 set means the shifted remainder
  // already exceeds 255, so the subtraction must be taken regardless of borrow.
  always_comb begin
    div_r8     = r_hi[7];
    div_rs     = {r_hi[6:0], r_lo[7]};
    div_accept = div_r8 | ~bus.alu_cy_i;
    div_r_nx   = div_accept ? bus.alu_o_i : div_rs;
    div_q_nx   = {r_lo[6:0], div_accept};
  end

  assign bypass = bus.op & (bus.b_i == 8'h00);
`else
  assign bypass = bus.op;
`endif

  always_comb begin
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_method = 3'd0;
    if (state == RUN) begin
`ifdef ALU_MULDIV_DIV_EN
      if (op_q) begin
        alu_a      = div_rs;
        alu_b      = m;
        alu_method = 3'd1;
      end else begin
        alu_a      = r_hi;
        alu_b      = mul_b;
        alu_method = 3'd0;
      end
`else
      alu_a      = r_hi;
      alu_b      = mul_b;
      alu_method = 3'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      r_hi   <= 8'h00;
      r_lo   <= 8'h00;
      m      <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      acc_q  <= 8'h00;
      b_q    <= 8'h00;
      ov_q   <= 1'b0;
      cy_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      op_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bypass) begin
              state  <= DONE;
              done_q <= 1'b1;
              acc_q  <= bus.acc_i;
              b_q    <= bus.b_i;
              ov_q   <= 1'b1;
              cy_q   <= 1'b0;
            end else begin
              state <= RUN;
              cnt   <= 3'd0;
              r_hi  <= 8'h00;
`ifdef ALU_MULDIV_DIV_EN
              op_q  <= bus.op;
              if (bus.op) begin
                r_lo <= bus.acc_i;
                m    <= bus.b_i;
              end else begin
                r_lo <= bus.b_i;
                m    <= bus.acc_i;
              end
`else
              r_lo  <= bus.b_i;
              m     <= bus.acc_i;
`endif
            end
          end
        end

        RUN: begin
          cnt <= cnt + 3'd1;
`ifdef ALU_MULDIV_DIV_EN
          if (op_q) begin
            r_hi <= div_r_nx;
            r_lo <= div_q_nx;
          end else begin
            r_hi <= mul_hi_nx;
            r_lo <= mul_lo_nx;
          end
`else
          r_hi <= mul_hi_nx;
          r_lo <= mul_lo_nx;
`endif
          if (cnt == 3'd7) begin
            state  <= DONE;
            done_q <= 1'b1;
            cy_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            if (op_q) begin
              acc_q <= div_q_nx;
              b_q   <= div_r_nx;
              ov_q  <= 1'b0;
            end else begin
              acc_q <= mul_lo_nx;
              b_q   <= mul_hi_nx;
              ov_q  <= (mul_hi_nx != 8'h00);
            end
`else
            acc_q <= mul_lo_nx;
            b_q   <= mul_hi_nx;
            ov_q  <= (mul_hi_nx != 8'h00);
`endif
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.acc_o        = acc_q;
  assign bus.b_o          = b_q;
  assign bus.ov_o         = ov_q;
  assign bus.cy_o         = cy_q;
  assign bus.alu_a_o      = alu_a;
  assign bus.alu_b_o      = alu_b;
  assign bus.alu_method_o = alu_method;
  assign bus.alu_cy_o     = 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed vector bench for alu_muldiv_seq with a behavioural ALU
module tb_alu_muldiv_seq;

  logic clk;
  logic rst;
  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] alu_res;
  always_comb begin
    if (bus.alu_method_o == 3'd1)
      alu_res = {1'b0, bus.alu_a_o} - {1'b0, bus.alu_b_o};
    else
      alu_res = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + {8'd0, bus.alu_cy_o};
  end
  assign bus.alu_o_i  = alu_res[7:0];
  assign bus.alu_cy_i = alu_res[8];

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_acc;
    logic [7:0] e_b;
    logic       e_ov;
    int         e_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request, then samples on falling edges until done (bounded).
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int meth_err, output int busy_err);
    bus.start = 1'b1; bus.op = o; bus.acc_i = a; bus.b_i = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; meth_err = 0; busy_err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!bus.busy) busy_err++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.alu_method_o != {2'b00, o} || bus.alu_cy_o != 1'b0) meth_err++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
  endtask

  int lat, meth_err, busy_err, pulses;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.acc_i = 8'h00; bus.b_i = 8'h00;

    vecs.push_back('{1'b0, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 9});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 9});
    vecs.push_back('{1'b0, 8'h80, 8'h02, 8'h00, 8'h01, 1'b1, 9});
    vecs.push_back('{1'b0, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b1, 8'h55, 8'h00, 8'h55, 8'h00, 1'b1, 1});
`ifdef ALU_MULDIV_DIV_EN
    vecs.push_back('{1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 9});
    vecs.push_back('{1'b1, 8'h07, 8'h09, 8'h00, 8'h07, 1'b0, 9});
    vecs.push_back('{1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b1, 8'hC8, 8'hC9, 8'h00, 8'hC8, 1'b0, 9});
`else
    vecs.push_back('{1'b1, 8'h40, 8'h02, 8'h40, 8'h02, 1'b1, 1});
    vecs.push_back('{1'b1, 8'hFB, 8'h12, 8'hFB, 8'h12, 1'b1, 1});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 0);
    check("reset done", {31'd0, bus.done}, 0);
    check("reset acc_o", {24'd0, bus.acc_o}, 0);
    check("reset b_o", {24'd0, bus.b_o}, 0);
    check("reset ov_cy", {30'd0, bus.ov_o, bus.cy_o}, 0);
    check("reset alu", {bus.alu_a_o, bus.alu_b_o, 5'd0, bus.alu_method_o, 7'd0, bus.alu_cy_o}, 0);
    rst = 1'b0;

    // Each vector starts in the cycle right after the previous done: back-to-back.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, meth_err, busy_err);
      check($sformatf("v%0d latency", i), lat, vecs[i].e_lat);
      check($sformatf("v%0d acc_o", i), {24'd0, bus.acc_o}, {24'd0, vecs[i].e_acc});
      check($sformatf("v%0d b_o", i), {24'd0, bus.b_o}, {24'd0, vecs[i].e_b});
      check($sformatf("v%0d ov_o", i), {31'd0, bus.ov_o}, {31'd0, vecs[i].e_ov});
      check($sformatf("v%0d cy_o", i), {31'd0, bus.cy_o}, 0);
      check($sformatf("v%0d busy drops", i), busy_err, 0);
      if (vecs[i].e_lat > 1) check($sformatf("v%0d alu method", i), meth_err, 0);
      @(negedge clk);
      check($sformatf("v%0d post done/busy", i), {30'd0, bus.done, bus.busy}, 0);
      check($sformatf("v%0d idle alu", i), {16'd0, bus.alu_a_o, bus.alu_b_o}, 0);
      check($sformatf("v%0d hold acc_o", i), {24'd0, bus.acc_o}, {24'd0, vecs[i].e_acc});
    end

    // start pulsed in cycle 4 of a RUN is ignored.
    bus.start = 1'b1; bus.op = 1'b0; bus.acc_i = 8'h0C; bus.b_i = 8'h0A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.acc_i = 8'hFF; bus.b_i = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int k = 5; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("ignored start latency", lat, 9);
    check("ignored start acc_o", {24'd0, bus.acc_o}, 32'h78);
    check("ignored start b_o", {24'd0, bus.b_o}, 0);
    @(negedge clk);
    check("ignored start no requeue", {31'd0, bus.busy}, 0);

    run_op(1'b0, 8'h50, 8'hA0, lat, meth_err, busy_err);
    check("b2b latency", lat, 9);
    check("b2b b_o", {24'd0, bus.b_o}, 32'h32);
    @(negedge clk);

    // rst in cycle 5 of RUN.
    bus.start = 1'b1; bus.op = 1'b0; bus.acc_i = 8'h0C; bus.b_i = 8'h0A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst mid busy/done", {30'd0, bus.busy, bus.done}, 0);
    check("rst mid results", {bus.acc_o, bus.b_o, 14'd0, bus.ov_o, bus.cy_o}, 0);
    check("rst mid alu", {bus.alu_a_o, bus.alu_b_o, 13'd0, bus.alu_method_o}, 0);
    count_done(12, pulses);
    check("rst mid no done", pulses, 0);

    run_op(1'b0, 8'hFF, 8'hFF, lat, meth_err, busy_err);
    check("post rst latency", lat, 9);
    check("post rst result", {16'd0, bus.b_o, bus.acc_o}, 32'hFE01);
    check("post rst ov", {31'd0, bus.ov_o}, 1);
    @(negedge clk);

    // rst together with start: rst wins.
    rst = 1'b1; bus.start = 1'b1; bus.op = 1'b0; bus.acc_i = 8'h03; bus.b_i = 8'h03;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("rst+start busy", {31'd0, bus.busy}, 0);
    check("rst+start cleared", {16'd0, bus.acc_o, bus.b_o}, 0);
    count_done(12, pulses);
    check("rst+start no done", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that executes the 8-bit MUL AB and DIV AB instructions by driving the shared combinational ALU for eight iterations. It sits between the instruction decoder and the ALU. While busy it owns the ALU operand, method and carry inputs, and it returns 8051-style results: A, B, OV, and CY cleared.

## Interface
Parameters:
- none

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = MUL, 1 = DIV; sampled with start
- acc_i  input  8  A operand: multiplicand or dividend
- b_i  input  8  B operand: multiplier or divisor
- busy  output  1  high from the cycle after start until done, inclusive
- done  output  1  one-cycle pulse; results valid from this cycle
- acc_o  output  8  MUL product low byte / DIV quotient
- b_o  output  8  MUL product high byte / DIV remainder
- ov_o  output  1  MUL: product > 255; DIV: divisor == 0
- cy_o  output  1  always 0 after an operation, per ISA
- alu_a_o  output  8  to ALU a
- alu_b_o  output  8  to ALU b
- alu_method_o  output  3  to ALU method (0 add, 1 sub)
- alu_cy_o  output  1  to ALU carry-in; always 0
- alu_o_i  input  8  ALU result
- alu_cy_i  input  1  ALU carry/borrow out (result bit 8)

## Operation
States: IDLE, RUN, DONE.
- IDLE to RUN: on start, if op = MUL, or op = DIV with b_i ≠ 0.
  - Latch the operands.
  - Set the iteration counter to 0.
- IDLE to DONE: on start with op = DIV and b_i = 0.
  - acc_o and b_o are set to acc_i and b_i unchanged.
  - ov_o = 1.
- RUN to DONE: after iteration 7 (counter 7).
- DONE to IDLE: unconditional, after one cycle.
- start while busy is ignored and not queued.

MUL (shift-add; registers P_hi = 0, P_lo = multiplier, M = multiplicand):
- ALU drive: alu_a_o = P_hi, alu_b_o = P_lo[0] ? M : 0, method = 0 (add).
- At the clock edge: {P_hi, P_lo} ← {alu_cy_i, alu_o_i, P_lo} >> 1.
- At the end: acc_o = P_lo, b_o = P_hi, ov_o = (P_hi ≠ 0).

DIV (restoring; registers R = 0, Q = dividend, D = divisor):
- Shift: {r8, R'} = {R, Q[7]}, a 9-bit value.
- ALU drive: alu_a_o = R'[7:0], alu_b_o = D, method = 1 (sub).
- Accept the subtraction if r8 = 1 or alu_cy_i = 0.
  - If accepted: R ← alu_o_i, Q ← {Q[6:0], 1}.
  - Otherwise: R ← R'[7:0], Q ← {Q[6:0], 0}.
- At the end: acc_o = Q, b_o = R, ov_o = 0.

Common rules:
- cy_o = 0 for every completed operation.
- Outside RUN, the ALU outputs are: alu_a_o = 0, alu_b_o = 0, alu_method_o = 0, alu_cy_o = 0.
- In RUN, the ALU outputs are combinational from registered state. The ALU is combinational, so each result is captured in the same cycle it is driven.

## Timing
- Reset values: state IDLE; busy, done, acc_o, b_o, ov_o, cy_o, and all alu_* outputs = 0.
- Normal latency, with start sampled at edge 0:
  - RUN occupies cycles 1–8.
  - done = 1 in cycle 9.
  - start is accepted again in cycle 10.
- DIV by zero: done in cycle 1; start accepted again in cycle 2.
- acc_o, b_o, ov_o and cy_o update only in DONE, and hold until the next DONE or reset.
- rst asserted during RUN or DONE: the next cycle is IDLE with reset values; no done pulse is produced.
- rst together with start: rst wins.

## Configuration
- ALU_MULDIV_DIV_EN defined: DIV is implemented as above.
- ALU_MULDIV_DIV_EN undefined: divide logic is removed.
  - op = 1 goes straight to DONE (done in cycle 1).
  - acc_o = acc_i, b_o = b_i, ov_o = 1, cy_o = 0.
  - MUL is unaffected.

## Test plan
- MUL 0x0C × 0x0A: done in cycle 9 → acc_o = 0x78, b_o = 0x00, ov_o = 0, cy_o = 0. During RUN, alu_method_o = 0 every cycle.
- MUL 0x50 × 0xA0 → acc_o = 0x00, b_o = 0x32, ov_o = 1. MUL 0xFF × 0xFF → acc_o = 0x01, b_o = 0xFE, ov_o = 1.
- DIV 0xFB / 0x12 → acc_o = 0x0D, b_o = 0x11, ov_o = 0. DIV 0x07 / 0x09 → acc_o = 0x00, b_o = 0x07.
- DIV 0x55 / 0x00: done in cycle 1 → acc_o = 0x55, b_o = 0x00, ov_o = 1. With the macro undefined, DIV 0x40 / 0x02 gives the same shape: done in cycle 1, acc_o = 0x40, b_o = 0x02, ov_o = 1.
- start pulsed in cycle 4 of a RUN: ignored, and the original result is unchanged. Back-to-back start in cycle 10 is accepted.
- rst in cycle 5 of RUN: cycle 6 shows busy = 0, all outputs 0, and no done pulse. A new MUL then completes correctly.
